seq_shift_add_mul: RTL and testbench

Parametrised sequential shift-and-add multiplier: the iterative successor to the fixed 32-bit array multiplier in the FastMultipliers family. It trades area for latency by retiring one multiplier bit per clock through a single WIDTH-bit adder. It supports signed and unsigned operands and carries a valid/ready handshake on both input and output. It is the small-area reference point benchmarked against the Wallace and Dadda trees.

---
 rtl/fm_pkg.sv | 19 +
 rtl/rca_adder.sv | 25 ++
 rtl/seq_shift_add_mul.sv | 99 +++++++++
 tb/tb_seq_shift_add_mul.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// Shared definitions for the FastMultipliers family: FSM state encoding and
// a width helper for iteration counters.
package fm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/rca_adder.sv
// Parametrised ripple-carry adder with carry-in and carry-out; the generalised
// form of the fixed 32-bit adder used elsewhere in the family.
module rca_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  // A procedural carry variable keeps the chain a single combinational loop body.
  always_comb begin
    logic carry;
    sum   = '0;
    carry = cin;
    for (int i = 0; i < WIDTH; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/seq_shift_add_mul.sv
// Iterative shift-and-add multiplier retiring one multiplier bit per clock,
// signed or unsigned, with valid/ready handshakes on both sides.
module seq_shift_add_mul
  import fm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] pro
);

  localparam int CW = clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mplier;
  logic             sign;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0]   sum;
  logic               cout;
  logic               accept;
  logic [2*WIDTH-1:0] prod_mag;

  // The most negative value maps onto itself, which reads correctly as unsigned 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v, input logic s);
    return (s && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  rca_adder #(.WIDTH(WIDTH)) u_add (
    .a   (acc),
    .b   (mplier[0] ? mcand : '0),
    .cin (1'b0),
    .sum (sum),
    .cout(cout)
  );

  assign accept   = in_valid && in_ready;
  assign prod_mag = {cout, sum, mplier[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = !rst;
        if (in_valid) state_nxt = BUSY;
      end
      BUSY: begin
        if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Carry-out lands in the accumulator MSB as the whole {acc, mplier} pair shifts right.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand  <= '0;
      acc    <= '0;
      mplier <= '0;
      sign   <= 1'b0;
      cnt    <= '0;
      pro    <= '0;
    end else if (accept) begin
      mcand  <= mag(a, is_signed);
      mplier <= mag(b, is_signed);
      acc    <= '0;
      sign   <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
      cnt    <= '0;
    end else if (state == BUSY) begin
      acc    <= {cout, sum[WIDTH-1:1]};
      mplier <= {sum[0], mplier[WIDTH-1:1]};
      cnt    <= cnt + 1'b1;
      if (cnt == LAST) pro <= sign ? (~prod_mag + 1'b1) : prod_mag;
    end
  end

endmodule

// File: tb/tb_seq_shift_add_mul.sv
// Self-checking bench for seq_shift_add_mul at WIDTH 8, 16 and 32: directed
// table, back-pressure and mid-operation reset sequences, and a random stream.
module tb_seq_shift_add_mul;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst8, iv8, s8, or8, ir8, ov8;
  logic [7:0]  a8, b8;
  logic [15:0] pro8;
  logic        rst16, iv16, s16, or16, ir16, ov16;
  logic [15:0] a16, b16;
  logic [31:0] pro16;
  logic        rst32, iv32, s32, or32, ir32, ov32;
  logic [31:0] a32, b32;
  logic [63:0] pro32;

  seq_shift_add_mul #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst8), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .is_signed(s8), .out_valid(ov8), .out_ready(or8), .pro(pro8));
  seq_shift_add_mul #(.WIDTH(16)) u16 (
    .clk(clk), .rst(rst16), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .out_valid(ov16), .out_ready(or16), .pro(pro16));
  seq_shift_add_mul #(.WIDTH(32)) u32 (
    .clk(clk), .rst(rst32), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(s32), .out_valid(ov32), .out_ready(or32), .pro(pro32));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          w;
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_in(input int w, input logic v, input logic [31:0] a, input logic [31:0] b, input logic s);
    case (w)
      8:       begin iv8  = v; a8  = a[7:0];  b8  = b[7:0];  s8  = s; end
      16:      begin iv16 = v; a16 = a[15:0]; b16 = b[15:0]; s16 = s; end
      default: begin iv32 = v; a32 = a;       b32 = b;       s32 = s; end
    endcase
  endtask

  task automatic set_or(input int w, input logic r);
    case (w)
      8:       or8  = r;
      16:      or16 = r;
      default: or32 = r;
    endcase
  endtask

  task automatic set_rst(input int w, input logic r);
    case (w)
      8:       rst8  = r;
      16:      rst16 = r;
      default: rst32 = r;
    endcase
  endtask

  function automatic logic get_ov(input int w);
    return (w == 8) ? ov8 : (w == 16) ? ov16 : ov32;
  endfunction

  function automatic logic get_ir(input int w);
    return (w == 8) ? ir8 : (w == 16) ? ir16 : ir32;
  endfunction

  function automatic logic [63:0] get_pro(input int w);
    return (w == 8) ? {48'b0, pro8} : (w == 16) ? {32'b0, pro16} : pro32;
  endfunction

  // Reference product from plain integer arithmetic, truncated to 2*w bits.
  function automatic logic [63:0] ref_mul(input int w, input logic [31:0] a, input logic [31:0] b, input logic s);
    longint      sa, sb;
    logic [63:0] p, mask;
    mask = (w == 32) ? '1 : ((64'd1 << (2 * w)) - 64'd1);
    if (s) begin
      sa = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
      sb = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
      p  = 64'(sa * sb);
    end else begin
      p = {32'b0, a} * {32'b0, b};
    end
    return p & mask;
  endfunction

  // One full transaction with out_ready held high; returns product and latency.
  task automatic apply_stimulus(input int w, input logic [31:0] a, input logic [31:0] b, input logic s,
                                output logic [63:0] p, output int lat);
    set_or(w, 1'b1);
    set_in(w, 1'b1, a, b, s);
    tick();
    set_in(w, 1'b0, $urandom, $urandom, 1'b0);
    lat = 0;
    while (!get_ov(w) && lat < 200) begin
      tick();
      lat++;
    end
    p = get_pro(w);
    tick();
  endtask

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] p, exp;
    logic [31:0] ra, rb;
    logic        rs;
    int          lat, seen;
    int          sent, recv, cyc, first_acc, last_acc;
    logic [63:0] q[$];

    vecs.push_back('{32, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001});
    vecs.push_back('{8,  32'h80, 32'h80, 1'b1, 64'h4000});
    vecs.push_back('{8,  32'h80, 32'h01, 1'b1, 64'hFF80});
    vecs.push_back('{8,  32'h05, 32'hFD, 1'b1, 64'hFFF1});
    vecs.push_back('{8,  32'h80, 32'h80, 1'b0, 64'h4000});
    vecs.push_back('{8,  32'h00, 32'hFF, 1'b0, 64'h0000});
    vecs.push_back('{16, 32'hFFFF, 32'hFFFF, 1'b0, 64'hFFFE0001});
    vecs.push_back('{16, 32'hFFFF, 32'hFFFF, 1'b1, 64'h00000001});
    vecs.push_back('{32, 32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000});
    vecs.push_back('{32, 32'hFFFFFFFF, 32'h00000002, 1'b1, 64'hFFFFFFFFFFFFFFFE});

    foreach (vecs[i]) begin
    end
    for (int w = 8; w <= 32; w = w * 2) begin
      set_rst(w, 1'b1);
      set_in(w, 1'b0, '0, '0, 1'b0);
      set_or(w, 1'b0);
    end

    tick();
    for (int w = 8; w <= 32; w = w * 2)
      check_output($sformatf("w%0d in_ready during reset", w), 64'(get_ir(w)), 64'd0);
    for (int w = 8; w <= 32; w = w * 2) set_rst(w, 1'b0);
    tick();
    for (int w = 8; w <= 32; w = w * 2) begin
      check_output($sformatf("w%0d reset in_ready", w), 64'(get_ir(w)), 64'd1);
      check_output($sformatf("w%0d reset out_valid", w), 64'(get_ov(w)), 64'd0);
      check_output($sformatf("w%0d reset pro", w), get_pro(w), 64'd0);
    end

    for (int i = 0; i < vecs.size(); i++) begin
      check_output($sformatf("vec%0d in_ready", i), 64'(get_ir(vecs[i].w)), 64'd1);
      apply_stimulus(vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].s, p, lat);
      check_output($sformatf("vec%0d pro", i), p, vecs[i].exp);
      check_output($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].w));
    end

    // Back-pressure: in_valid pulses during BUSY and DONE must be ignored.
    exp = ref_mul(16, 32'h1234, 32'h5678, 1'b0);
    set_or(16, 1'b0);
    set_in(16, 1'b1, 32'h1234, 32'h5678, 1'b0);
    tick();
    lat = 0;
    while (!ov16 && lat < 200) begin
      set_in(16, lat[0], 32'hFFFF, 32'h8001, 1'b1);
      tick();
      lat++;
    end
    check_output("hold latency", 64'(lat), 64'd16);
    for (int h = 0; h < 10; h++) begin
      set_in(16, 1'b1, $urandom, $urandom, 1'b1);
      check_output($sformatf("hold%0d pro", h), {32'b0, pro16}, exp);
      check_output($sformatf("hold%0d ov/ir", h), {62'b0, ov16, ir16}, 64'd2);
      tick();
    end
    set_in(16, 1'b0, '0, '0, 1'b0);
    set_or(16, 1'b1);
    tick();
    check_output("release ov/ir", {62'b0, ov16, ir16}, 64'd1);
    check_output("release pro", {32'b0, pro16}, exp);

    // Reset at iteration 7 discards the partial result.
    set_in(16, 1'b1, 32'h1234, 32'h5678, 1'b0);
    tick();
    set_in(16, 1'b0, '0, '0, 1'b0);
    repeat (6) tick();
    set_rst(16, 1'b1);
    tick();
    check_output("midrst out_valid", 64'(ov16), 64'd0);
    check_output("midrst pro", {32'b0, pro16}, 64'd0);
    check_output("midrst in_ready", 64'(ir16), 64'd0);
    set_rst(16, 1'b0);
    seen = 0;
    repeat (20) begin
      tick();
      if (ov16) seen++;
    end
    check_output("midrst no late result", 64'(seen), 64'd0);
    check_output("midrst idle", 64'(ir16), 64'd1);
    apply_stimulus(16, 32'd3, 32'd4, 1'b0, p, lat);
    check_output("after rst pro", p, 64'd12);
    check_output("after rst latency", 64'(lat), 64'd16);

    // Random back-to-back stream against the scoreboard.
    sent = 0; recv = 0; cyc = 0; first_acc = -1; last_acc = 0;
    set_or(32, 1'b1);
    while (recv < 1000 && cyc < 40000) begin
      if (ov32) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("[TB] FAIL stream extra: got %h expected none", pro32);
        end else begin
          exp = q.pop_front();
          check_output($sformatf("stream%0d pro", recv), pro32, exp);
        end
        recv++;
      end
      if (ir32 && sent < 1000) begin
        case ($urandom_range(0, 7))
          0:       ra = 32'h80000000;
          1:       ra = 32'h0;
          2:       ra = 32'hFFFFFFFF;
          default: ra = $urandom;
        endcase
        case ($urandom_range(0, 7))
          0:       rb = 32'h80000000;
          1:       rb = 32'h0;
          2:       rb = 32'hFFFFFFFF;
          default: rb = $urandom;
        endcase
        rs = 1'($urandom_range(0, 1));
        set_in(32, 1'b1, ra, rb, rs);
        q.push_back(ref_mul(32, ra, rb, rs));
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        sent++;
      end else begin
        set_in(32, 1'b0, $urandom, $urandom, 1'b0);
      end
      tick();
      cyc++;
    end
    check_output("stream received", 64'(recv), 64'd1000);
    check_output("stream leftover", 64'(q.size()), 64'd0);
    check_output("stream throughput", 64'(last_acc - first_acc), 64'(999 * 34));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
